// File: rtl/icache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the fetch-side
// instruction cache.
package icache_pkg;

   // Cache geometry. The top-level LINES/WORDS parameters must match these.
   localparam int unsigned DEF_LINES = 16;
   localparam int unsigned DEF_WORDS = 4;
   localparam int unsigned INDEX_W   = $clog2(DEF_LINES);
   localparam int unsigned OFFSET_W  = $clog2(DEF_WORDS);
   localparam int unsigned TAG_W     = 30 - INDEX_W - OFFSET_W;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StMissReq,
      StRefill,
      StDone
   } state_e;

   // Helpers take the word address (byte address bits [31:2]).
   function automatic logic [TAG_W-1:0] addr_tag(input logic [29:0] wa);
      return wa[29 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [29:0] wa);
      return wa[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_offset(input logic [29:0] wa);
      return wa[OFFSET_W-1:0];
   endfunction

   function automatic logic [31:0] line_addr(input logic [29:0] wa);
      return {wa[29:OFFSET_W], {(OFFSET_W + 2){1'b0}}};
   endfunction

endpackage

// File: rtl/icache_tag_ram.sv
// Valid+tag array for the instruction cache: synchronous read, single write
// port, valid bits cleared asynchronously on reset.
module icache_tag_ram
   import icache_pkg::*;
#(
   parameter int unsigned LINES = DEF_LINES
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               rd_en,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem [LINES];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
         end
         if (rd_en) begin
            rd_valid <= valid_q[rd_index];
         end
      end
   end

   // Tag storage needs no reset: it is only trusted behind a valid bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index] <= wr_tag;
      end
      if (rd_en) begin
         rd_tag <= tag_mem[rd_index];
      end
   end

endmodule

// File: rtl/fetch_icache.sv
// Direct-mapped instruction cache serving the IF fetch port; hits answer one
// cycle after the request, misses refill a whole line by burst.
module fetch_icache
   import icache_pkg::*;
#(
   parameter int unsigned LINES = DEF_LINES,
   parameter int unsigned WORDS = DEF_WORDS
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   input  logic        fetch_cancel,
   output logic [31:0] fetch_inst,
   output logic        fetch_ready,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS - 1);

   state_e              state_q, state_d;
   logic [29:0]         addr_q, addr_d;
   logic [OFFSET_W-1:0] cnt_q, cnt_d;
   logic                cancel_q, cancel_d;
   logic [31:0]         resp_q, resp_d;

   logic                rd_en, tag_we, data_we, accept, hit;
   logic                rd_valid;
   logic [TAG_W-1:0]    rd_tag;
   logic [31:0]         rd_word_q;
   logic [31:0]         data_mem [LINES*WORDS];
   logic [29:0]         fetch_wa;
   logic                unused_addr_bits;

   assign fetch_wa         = fetch_addr[31:2];
   assign unused_addr_bits = ^fetch_addr[1:0];
   assign accept           = fetch_req && !fetch_cancel;
   assign hit              = rd_valid && (rd_tag == addr_tag(addr_q));
   assign mem_addr         = mem_req ? line_addr(addr_q) : '0;

   icache_tag_ram #(
      .LINES (LINES)
   ) u_tag_ram (
      .clk      (clk),
      .resetn   (resetn),
      .rd_en    (rd_en),
      .rd_index (addr_index(fetch_wa)),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .wr_en    (tag_we),
      .wr_index (addr_index(addr_q)),
      .wr_tag   (addr_tag(addr_q))
   );

   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[{addr_index(addr_q), cnt_q}] <= mem_rdata;
      end
      if (rd_en) begin
         rd_word_q <= data_mem[{addr_index(fetch_wa), addr_offset(fetch_wa)}];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         cnt_q    <= '0;
         cancel_q <= 1'b0;
         resp_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         cancel_q <= cancel_d;
         resp_q   <= resp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      cancel_d    = cancel_q;
      resp_d      = resp_q;
      rd_en       = 1'b0;
      tag_we      = 1'b0;
      data_we     = 1'b0;
      fetch_ready = 1'b0;
      fetch_inst  = '0;
      mem_req     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d  = fetch_wa;
               rd_en   = 1'b1;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (fetch_cancel) begin
               state_d = StIdle;
            end else if (hit) begin
               fetch_ready = 1'b1;
               fetch_inst  = rd_word_q;
               if (fetch_req) begin
                  addr_d = fetch_wa;
                  rd_en  = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               state_d = StMissReq;
            end
         end
         StMissReq: begin
            mem_req = 1'b1;
            // A grant commits the burst even if IF redirects in the same cycle.
            if (mem_gnt) begin
               cnt_d    = '0;
               cancel_d = fetch_cancel;
               state_d  = StRefill;
            end else if (fetch_cancel) begin
               state_d = StIdle;
            end
         end
         StRefill: begin
            if (fetch_cancel) begin
               cancel_d = 1'b1;
            end
            if (mem_rvalid) begin
               data_we = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == addr_offset(addr_q)) begin
                  resp_d = mem_rdata;
               end
               if (cnt_q == LAST_WORD) begin
                  tag_we   = 1'b1;
                  cancel_d = 1'b0;
                  state_d  = (cancel_q || fetch_cancel) ? StIdle : StDone;
               end
            end
         end
         StDone: begin
            if (!fetch_cancel) begin
               fetch_ready = 1'b1;
               fetch_inst  = resp_q;
            end
            if (accept) begin
               addr_d  = fetch_wa;
               rd_en   = 1'b1;
               state_d = StLookup;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule
